volume_ramp: RTL and testbench



---
 rtl/volume_ramp.sv | 79 +++++++
 tb/tb_volume_ramp.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/volume_ramp.sv
// rtl/volume_ramp.sv - slews the volume word toward a target on sample_tick boundaries
// Provides soft mute (fade to 0) and soft start (fade up from 0 after reset).
module volume_ramp #(
  parameter int VOLUME_BITS    = 8,
  parameter int STEP           = 1,
  parameter int TICKS_PER_STEP = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sample_tick,
  input  logic [VOLUME_BITS-1:0] target_volume,
  input  logic                   mute_req,
  output logic [VOLUME_BITS-1:0] volume,
  output logic                   ramp_active,
  output logic                   muted
);

  localparam int PW = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_STEP - 1);
  localparam logic [VOLUME_BITS:0] STEP_W = (VOLUME_BITS + 1)'(STEP);

  typedef enum logic [1:0] {STEADY, UP, DOWN, MUTED} state_t;

  state_t                 state;
  logic [VOLUME_BITS-1:0] eff_target;
  logic [VOLUME_BITS-1:0] volume_nxt;
  logic [PW-1:0]          prescaler;
  logic [PW-1:0]          prescaler_nxt;
  logic [VOLUME_BITS:0]   up_sum;
  logic [VOLUME_BITS:0]   down_diff;
  logic                   step_now;

  // State is derived every cycle from the registered volume, so a target or
  // mute change redirects the ramp without restarting the prescaler.
  always_comb begin
    eff_target    = mute_req ? '0 : target_volume;
    up_sum        = {1'b0, volume} + STEP_W;
    down_diff     = {1'b0, volume} - STEP_W;
    step_now      = sample_tick && (prescaler == PRE_LAST);
    volume_nxt    = volume;
    prescaler_nxt = prescaler;

    if (mute_req && (volume == '0))  state = MUTED;
    else if (volume == eff_target)   state = STEADY;
    else if (volume < eff_target)    state = UP;
    else                             state = DOWN;

    unique case (state)
      UP: begin
        if (sample_tick) prescaler_nxt = step_now ? '0 : PW'(prescaler + 1'b1);
        if (step_now)
          volume_nxt = (up_sum > {1'b0, eff_target}) ? eff_target : up_sum[VOLUME_BITS-1:0];
      end
      DOWN: begin
        if (sample_tick) prescaler_nxt = step_now ? '0 : PW'(prescaler + 1'b1);
        // A borrow in the top bit means the step went below zero: clamp to target.
        if (step_now)
          volume_nxt = (down_diff[VOLUME_BITS] || (down_diff < {1'b0, eff_target}))
                       ? eff_target : down_diff[VOLUME_BITS-1:0];
      end
      default: prescaler_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      volume      <= '0;
      prescaler   <= '0;
      ramp_active <= 1'b0;
      muted       <= 1'b1;
    end else begin
      volume      <= volume_nxt;
      prescaler   <= prescaler_nxt;
      ramp_active <= (volume_nxt != eff_target);
      muted       <= mute_req && (volume_nxt == '0);
    end
  end

endmodule

// File: tb/tb_volume_ramp.sv
// tb/tb_volume_ramp.sv - bench for volume_ramp across several STEP/TICKS_PER_STEP settings
// Six instances share stimulus; an integer model predicts every output each cycle.
module tb_volume_ramp;

  localparam int N = 6;
  localparam int SS [N] = '{1, 4, 16, 8, 4, 1};
  localparam int TT [N] = '{4, 2, 1, 3, 1, 1};

  logic       clk = 1'b0;
  logic       rst;
  logic       sample_tick;
  logic [7:0] target_volume;
  logic       mute_req;
  logic [7:0] dv [N];
  logic       dr [N];
  logic       dm [N];

  int mv [N];
  int mp [N];
  bit mr [N];
  bit mm [N];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    volume_ramp #(
      .VOLUME_BITS   (8),
      .STEP          (SS[g]),
      .TICKS_PER_STEP(TT[g])
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .sample_tick  (sample_tick),
      .target_volume(target_volume),
      .mute_req     (mute_req),
      .volume       (dv[g]),
      .ramp_active  (dr[g]),
      .muted        (dm[g])
    );
  end

  // Reference: count ticks while away from the target; every TICKS_PER_STEP-th
  // tick moves volume STEP closer, never past the target.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        mv[i] = 0; mp[i] = 0; mr[i] = 0; mm[i] = 1;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        int eff;
        int v;
        eff = mute_req ? 0 : int'(target_volume);
        v   = mv[i];
        if (v == eff) begin
          mp[i] = 0;
        end else if (sample_tick) begin
          if (mp[i] == TT[i] - 1) begin
            mp[i] = 0;
            if (v < eff) v = (v + SS[i] > eff) ? eff : v + SS[i];
            else         v = (v - SS[i] < eff) ? eff : v - SS[i];
          end else begin
            mp[i] = mp[i] + 1;
          end
        end
        mv[i] = v;
        mr[i] = (v != eff);
        mm[i] = mute_req && (v == 0);
      end
    end
  end

  task automatic chk(input string name, input int inst, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s inst%0d t=%0t actual=%0d required=%0d", name, inst, $time, act, exp);
    end
  endtask

  task automatic checker_loop();
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        chk("volume", i, int'(dv[i]), mv[i]);
        chk("ramp_active", i, int'(dr[i]), int'(mr[i]));
        chk("muted", i, int'(dm[i]), int'(mm[i]));
      end
    end
  endtask

  task automatic tick();
    sample_tick = 1'b1;
    @(posedge clk); #2;
    sample_tick = 1'b0;
    @(posedge clk); #2;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #2;
  endtask

  initial begin
    int exp1 [7];
    int prev;
    exp1 = '{0, 0, 4, 4, 8, 8, 10};
    rst = 1'b0; sample_tick = 1'b0; target_volume = 8'd10; mute_req = 1'b0;
    #1 rst = 1'b1;
    fork checker_loop(); join_none
    @(posedge clk); #2;
    for (int i = 0; i < N; i++) begin
      chk("rst_volume", i, int'(dv[i]), 0);
      chk("rst_muted", i, int'(dm[i]), 1);
      chk("rst_ramp", i, int'(dr[i]), 0);
    end

    // Soft start, STEP=4 TICKS=2
    rst = 1'b0;
    @(posedge clk); #2;
    chk("t1_vol", 1, int'(dv[1]), exp1[0]);
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("t1_vol", 1, int'(dv[1]), exp1[k]);
    end
    chk("t1_ramp_done", 1, int'(dr[1]), 0);

    // Soft mute from full scale, STEP=16 TICKS=1
    target_volume = 8'd255;
    do_reset();
    ticks(16);
    chk("t2_full", 2, int'(dv[2]), 255);
    mute_req = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk("t2_vol", 2, int'(dv[2]), (255 - 16 * k < 0) ? 0 : 255 - 16 * k);
    end
    chk("t2_muted", 2, int'(dm[2]), 1);
    chk("t2_ramp", 2, int'(dr[2]), 0);
    mute_req = 1'b0;

    // Redirect mid-ramp, STEP=1 TICKS=1
    target_volume = 8'd100;
    do_reset();
    ticks(50);
    chk("t3_mid", 5, int'(dv[5]), 50);
    target_volume = 8'd20;
    tick();
    chk("t3_reverse", 5, int'(dv[5]), 49);
    prev = 49;
    for (int k = 0; k < 30; k++) begin
      tick();
      n_cmp++;
      if (int'(dv[5]) > prev) begin
        n_bad++;
        $display("FAIL t3_monotonic inst5 actual=%0d required<=%0d", dv[5], prev);
      end
      prev = int'(dv[5]);
    end
    chk("t3_end", 5, int'(dv[5]), 20);

    // No ticks means no movement, STEP=8 TICKS=3
    target_volume = 8'd40;
    do_reset();
    ticks(20);
    chk("t4_steady", 3, int'(dv[3]), 40);
    target_volume = 8'd200;
    repeat (1000) @(posedge clk);
    #2;
    chk("t4_hold", 3, int'(dv[3]), 40);
    chk("t4_ramp", 3, int'(dr[3]), 1);
    tick(); chk("t4_tick1", 3, int'(dv[3]), 40);
    tick(); chk("t4_tick2", 3, int'(dv[3]), 40);
    tick(); chk("t4_tick3", 3, int'(dv[3]), 48);

    // Unmute mid fade-out, STEP=4 TICKS=1
    target_volume = 8'd128;
    do_reset();
    ticks(32);
    chk("t5_top", 4, int'(dv[4]), 128);
    mute_req = 1'b1;
    ticks(17);
    chk("t5_fade", 4, int'(dv[4]), 60);
    mute_req = 1'b0;
    tick();
    chk("t5_up", 4, int'(dv[4]), 64);
    for (int k = 0; k < 16; k++) begin
      tick();
      chk("t5_muted", 4, int'(dm[4]), 0);
    end
    chk("t5_end", 4, int'(dv[4]), 128);

    // Asynchronous reset mid-ramp
    target_volume = 8'd200;
    do_reset();
    ticks(10);
    chk("t6_pre", 0, int'(dv[0]), 2);
    #1 rst = 1'b1;
    #1;
    for (int i = 0; i < N; i++) begin
      chk("t6_async_vol", i, int'(dv[i]), 0);
      chk("t6_async_muted", i, int'(dm[i]), 1);
    end
    @(posedge clk); #2;
    rst = 1'b0;
    ticks(8);
    chk("t6_restart", 0, int'(dv[0]), 2);

    // Randomized traffic
    for (int c = 0; c < 6000; c++) begin
      sample_tick = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 59) == 0) begin
        case ($urandom_range(0, 3))
          0:       target_volume = 8'd0;
          1:       target_volume = 8'd255;
          default: target_volume = 8'($urandom_range(0, 255));
        endcase
      end
      if ($urandom_range(0, 199) == 0) mute_req = ~mute_req;
      rst = ($urandom_range(0, 1999) == 0);
      @(posedge clk); #2;
    end
    rst = 1'b0;
    sample_tick = 1'b0;
    @(posedge clk); #2;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
